vga_scanout: RTL and testbench

- Reads the displayed framebuffer, one pixel per pixel period, and drives 640x480@60 VGA timing to the board DAC.
- Each 320x240 framebuffer pixel is shown as a 2x2 block of screen pixels.
- Sits between `framebuffer_module` (read port: coordinates out, palette color back, new-frame pulse) and the VGA pins.
- Generates the `new_frame` pulse that lets the framebuffer swap buffers during vertical blanking.

---
 rtl/vga_scanout.sv | 136 +++++++++++++
 tb/tb_vga_scanout.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing with 2x2 pixel doubling from a 320x240 framebuffer.
// Latency: pins lag the counters by one pixel period (2 Clk); fb_color is consumed 1 Clk after fb_coords.
// Backpressure: none; free-running raster, and the framebuffer read port must answer in exactly 1 Clk.
//
// Ports:
//   Clk, Reset           50 MHz system clock, synchronous active-high reset
//   fb_coords / fb_color framebuffer read port (coordinates out, palette index back one Clk later)
//   new_frame            one-Clk pulse when the raster enters vertical blanking
//   vga_clk, hsync, vsync, blank_n, red, green, blue  VGA DAC pins

package vga_scanout_pkg;
  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
  } screen_xy_t;

  typedef logic [2:0] palcolor_t;
endpackage

module vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic                         Clk,
  input  logic                         Reset,
  output vga_scanout_pkg::screen_xy_t  fb_coords,
  input  vga_scanout_pkg::palcolor_t   fb_color,
  output logic                         new_frame,
  output logic                         vga_clk,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         blank_n,
  output logic [3:0]                   red,
  output logic [3:0]                   green,
  output logic [3:0]                   blue
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic                        phase;
  logic                        tick;
  logic [HW-1:0]               hc;
  logic [VW-1:0]               vc;
  logic [HW-1:0]               hc_adv;
  logic [VW-1:0]               vc_adv;
  vga_scanout_pkg::screen_xy_t coords_adv;
  logic                        active;
  logic                        hs_raw;
  logic                        vs_raw;
  logic                        frame_hit;

  // Stage 1: decode of the counter value whose framebuffer read is in flight.
  logic                        s1_active;
  logic                        s1_hs;
  logic                        s1_vs;

  assign tick    = phase;
  assign vga_clk = phase;

  always_comb begin
    hc_adv = hc + 1'b1;
    vc_adv = vc;
    if (hc == H_LAST) begin
      hc_adv = '0;
      vc_adv = (vc == V_LAST) ? '0 : vc + 1'b1;
    end

    // Coordinates are derived from the value the counters are about to take,
    // so the read is issued in the same tick the counters move.
    coords_adv   = '0;
    coords_adv.x = (hc_adv < H_ACT) ? 9'(hc_adv >> 1) : 9'd0;
    coords_adv.y = (vc_adv < V_ACT) ? 8'(vc_adv >> 1) : 8'd0;

    active    = (hc < H_ACT) && (vc < V_ACT);
    hs_raw    = !((hc >= HS_FIRST) && (hc <= HS_LAST));
    vs_raw    = !((vc >= VS_FIRST) && (vc <= VS_LAST));
    frame_hit = (hc_adv == '0) && (vc_adv == V_ACT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      phase     <= 1'b0;
      hc        <= '0;
      vc        <= '0;
      fb_coords <= '0;
      new_frame <= 1'b0;
      s1_active <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      blank_n   <= 1'b0;
      red       <= 4'h0;
      green     <= 4'h0;
      blue      <= 4'h0;
    end else begin
      phase     <= ~phase;
      new_frame <= tick && frame_hit;
      if (tick) begin
        hc        <= hc_adv;
        vc        <= vc_adv;
        fb_coords <= coords_adv;
        // Stage 2: fb_color now holds the read for the stage-1 counter value.
        hsync     <= s1_hs;
        vsync     <= s1_vs;
        blank_n   <= s1_active;
        red       <= s1_active ? {4{fb_color[2]}} : 4'h0;
        green     <= s1_active ? {4{fb_color[1]}} : 4'h0;
        blue      <= s1_active ? {4{fb_color[0]}} : 4'h0;
      end else begin
        s1_active <= active;
        s1_hs     <= hs_raw;
        s1_vs     <= vs_raw;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout using a reduced raster so several whole frames fit in a short run.
// Expected pins are computed from the pixel index elapsed since reset release.

module tb_vga_scanout;
  import vga_scanout_pkg::*;

  localparam int HV = 20, HF = 2, HS = 4, HB = 2;
  localparam int VV = 16, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int F  = HT * VT;

  logic       Clk = 1'b0;
  logic       Reset;
  screen_xy_t fb_coords;
  palcolor_t  fb_color;
  logic       new_frame, vga_clk, hsync, vsync, blank_n;
  logic [3:0] red, green, blue;

  logic [2:0] mem [0:15][0:15];

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int hs_low, vs_low, bl_high, nf_cnt, nf_first, nf_second, red_cnt;

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .Clk(Clk), .Reset(Reset), .fb_coords(fb_coords), .fb_color(fb_color),
    .new_frame(new_frame), .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync),
    .blank_n(blank_n), .red(red), .green(green), .blue(blue)
  );

  always #10 Clk = ~Clk;

  // Framebuffer read port: registered read, one Clk latency.
  always @(posedge Clk) begin
    if (fb_coords.y < 8'd16 && fb_coords.x < 9'd16)
      fb_color <= mem[fb_coords.y][fb_coords.x];
    else
      fb_color <= 3'b000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // {vga_clk, hsync, vsync, blank_n, new_frame, red, green, blue} after edge kk.
  function automatic logic [31:0] pins_for(input int kk);
    int m, h, v;
    logic act, hsn, vsn, nf, vclk;
    logic [2:0] c;
    vclk = (kk % 2) == 1;
    if (kk < 2) return {15'b0, vclk, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
    m   = kk / 2 - 1;
    h   = m % HT;
    v   = (m / HT) % VT;
    act = (h < HV) && (v < VV);
    hsn = !(h >= HV + HF && h < HV + HF + HS);
    vsn = !(v >= VV + VF && v < VV + VF + VS);
    nf  = ((kk % 2) == 0) && (((kk / 2) % F) == VV * HT);
    c   = act ? mem[v / 2][h / 2] : 3'b000;
    return {15'b0, vclk, hsn, vsn, act, nf, {4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction

  function automatic logic [31:0] coords_for(input int kk);
    int n, h, v;
    logic [8:0] x;
    logic [7:0] y;
    n = kk / 2;
    h = n % HT;
    v = (n / HT) % VT;
    x = (h < HV) ? 9'(h / 2) : 9'd0;
    y = (v < VV) ? 8'(v / 2) : 8'd0;
    return {15'b0, x, y};
  endfunction

  task automatic fill(input int mode);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        case (mode)
          0:       mem[y][x] = 3'($urandom);
          1:       mem[y][x] = (x == 5 && y == 7) ? 3'b101 : 3'b000;
          default: mem[y][x] = 3'b111;
        endcase
  endtask

  // Holds Reset for n Clk checking reset values, then releases it.
  task automatic do_reset(input int n);
    Reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      chk("reset_pins", {15'b0, vga_clk, hsync, vsync, blank_n, new_frame, red, green, blue},
          {15'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000});
      chk("reset_coords", {15'b0, fb_coords}, 32'd0);
    end
    Reset     = 1'b0;
    k         = 0;
    hs_low    = 0;
    vs_low    = 0;
    bl_high   = 0;
    nf_cnt    = 0;
    nf_first  = -1;
    nf_second = -1;
    red_cnt   = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      k++;
      chk("pins", {15'b0, vga_clk, hsync, vsync, blank_n, new_frame, red, green, blue}, pins_for(k));
      chk("coords", {15'b0, fb_coords}, coords_for(k));
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (blank_n) bl_high++;
      if (red == 4'hF) red_cnt++;
      if (new_frame) begin
        nf_cnt++;
        if (nf_cnt == 1) nf_first = k;
        else if (nf_cnt == 2) nf_second = k;
      end
    end
  endtask

  initial begin
    Reset = 1'b1;

    // Random framebuffer contents, two full frames.
    fill(0);
    do_reset(3);
    run(2 * F + 1);
    chk("hsync_low_clk", hs_low, 2 * HS * VT);
    chk("vsync_low_clk", vs_low, 2 * VS * HT);
    chk("blank_n_high_clk", bl_high, 2 * HV * VV);
    chk("new_frame_count", nf_cnt, 1);
    chk("new_frame_first", nf_first, 2 * VV * HT);
    run(2 * F);
    chk("new_frame_count2", nf_cnt, 2);
    chk("new_frame_period", nf_second - nf_first, 2 * F);

    // Single lit framebuffer pixel at (5,7).
    fill(1);
    do_reset(3);
    run(2 * F + 1);
    chk("single_pixel_red_clk", red_cnt, 8);

    // Framebuffer all 3'b111: colour only inside the visible region.
    fill(2);
    do_reset(2);
    run(2 * F + 1);
    chk("full_white_red_clk", red_cnt, 2 * HV * VV);
    chk("full_white_blank_clk", bl_high, 2 * HV * VV);

    // Reset mid-frame at a fixed point, then the next pulse after release.
    fill(0);
    do_reset(4);
    run(2 * (10 * HT + 13));
    do_reset(3);
    run(2 * VV * HT + 4);
    chk("midreset_nf_count", nf_cnt, 1);
    chk("midreset_nf_first", nf_first, 2 * VV * HT);

    // Reset at a random point with a random length.
    run(int'($urandom_range(1, 2 * F)));
    do_reset(int'($urandom_range(1, 5)));
    run(2 * F + 1);
    chk("randreset_nf_first", nf_first, 2 * VV * HT);
    chk("randreset_hsync_low", hs_low, 2 * HS * VT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
